// File: rtl/uram_row_arbiter_if.sv
// uram_row_arbiter_if: core row-sync handshake, per-core URAM ports and the physical URAM/drain side
interface uram_row_arbiter_if #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [NUM_CORES-1:0] i_core_req;
  logic [NUM_CORES-1:0] o_core_grant;
  logic [NUM_CORES-1:0] i_core_locked;
  logic [NUM_CORES-1:0] i_core_uram_en;
  logic [NUM_CORES*ADDR_W-1:0] i_core_uram_addr;
  logic [NUM_CORES*DATA_W-1:0] i_core_uram_wr_data;
  logic [NUM_CORES-1:0] i_core_uram_wr_en;
  logic o_uram_en;
  logic [ADDR_W-1:0] o_uram_addr;
  logic [DATA_W-1:0] o_uram_wr_data;
  logic o_uram_wr_en;
  logic o_uram_emptied;
  logic o_drain_req;
  logic i_drain_done;
  logic [$clog2(NUM_CORES)-1:0] o_active_core;
`ifdef URAM_ARB_TIMEOUT_EN
  logic o_timeout;
`endif
  modport slave (
    input i_core_req, i_core_locked, i_core_uram_en, i_core_uram_addr, i_core_uram_wr_data,
    input i_core_uram_wr_en, i_drain_done,
`ifdef URAM_ARB_TIMEOUT_EN
    output o_timeout,
`endif
    output o_core_grant, o_uram_en, o_uram_addr, o_uram_wr_data, o_uram_wr_en,
    output o_uram_emptied, o_drain_req, o_active_core
  );
  modport master (
    output i_core_req, i_core_locked, i_core_uram_en, i_core_uram_addr, i_core_uram_wr_data,
    output i_core_uram_wr_en, i_drain_done,
`ifdef URAM_ARB_TIMEOUT_EN
    input o_timeout,
`endif
    input o_core_grant, o_uram_en, o_uram_addr, o_uram_wr_data, o_uram_wr_en,
    input o_uram_emptied, o_drain_req, o_active_core
  );
endinterface

// File: rtl/uram_row_arbiter.sv
// uram_row_arbiter: round-robin row URAM arbiter with drain barrier once every core has had a session.
// Optional grant-to-lock timeout with o_timeout pulse when URAM_ARB_TIMEOUT_EN is defined.
module uram_row_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic reset,
  uram_row_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_CORES);
  if (NUM_CORES < 2 || NUM_CORES > 16) begin : g_bad_cores
    $error("NUM_CORES must be 2..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end
  typedef enum logic [1:0] {IDLE, WAIT_LOCK, LOCKED, DRAIN} state_t;
  state_t state_q, state_d;
  logic [NUM_CORES-1:0] grant_q, grant_d, done_q, done_d;
  logic [IW-1:0] idx_q, idx_d, ptr_q, ptr_d, sel, idx_inc;
  logic found, fwd;
  logic uram_en_q, uram_en_d, wr_en_q, wr_en_d;
  logic emptied_q, emptied_d, drain_req_q, drain_req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
`ifdef URAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic timeout_q, timeout_d;
`endif
  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v >= NUM_CORES ? v - NUM_CORES : v);
  endfunction
  assign idx_inc = (idx_q == IW'(NUM_CORES - 1)) ? '0 : idx_q + 1'b1;
  // Scan from farthest to nearest so the first eligible core at/after the pointer wins.
  always_comb begin
    sel = '0;
    found = 1'b0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (bus.i_core_req[wrap(int'(ptr_q) + i)] && !done_q[wrap(int'(ptr_q) + i)]) begin
        sel = wrap(int'(ptr_q) + i);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d = idx_q;
    done_d = done_q;
    ptr_d = ptr_q;
    drain_req_d = 1'b0;
`ifdef URAM_ARB_TIMEOUT_EN
    timeout_d = 1'b0;
    cnt_d = (state_q == WAIT_LOCK) ? cnt_q + 1'b1 : '0;
`endif
    case (state_q)
      IDLE: begin
        if (&done_q) begin
          state_d = DRAIN;
          drain_req_d = 1'b1;
        end else if (found) begin
          state_d = WAIT_LOCK;
          grant_d = NUM_CORES'(1) << sel;
          idx_d = sel;
        end
      end
      WAIT_LOCK: begin
        if (bus.i_core_locked[idx_q]) begin
          state_d = LOCKED;
        end else if (!bus.i_core_req[idx_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end
`ifdef URAM_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          grant_d = '0;
          done_d[idx_q] = 1'b1;
          ptr_d = idx_inc;
          timeout_d = 1'b1;
        end
`endif
      end
      LOCKED: begin
        if (!bus.i_core_locked[idx_q]) begin
          state_d = IDLE;
          grant_d = '0;
          done_d[idx_q] = 1'b1;
          ptr_d = idx_inc;
        end
      end
      DRAIN: begin
        drain_req_d = !bus.i_drain_done;
        if (bus.i_drain_done) begin
          state_d = IDLE;
          done_d = '0;
          ptr_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign fwd = (state_q == WAIT_LOCK) || (state_q == LOCKED);
  always_comb begin
    uram_en_d = fwd & bus.i_core_uram_en[idx_q];
    wr_en_d = fwd & bus.i_core_uram_wr_en[idx_q];
    addr_d = fwd ? bus.i_core_uram_addr[idx_q*ADDR_W +: ADDR_W] : addr_q;
    data_d = fwd ? bus.i_core_uram_wr_data[idx_q*DATA_W +: DATA_W] : data_q;
    emptied_d = (state_q == DRAIN && bus.i_drain_done) ? 1'b1 :
                (uram_en_q & wr_en_q) ? 1'b0 : emptied_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q <= '0;
      done_q <= '0;
      ptr_q <= '0;
      uram_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      emptied_q <= 1'b1;
      drain_req_q <= 1'b0;
`ifdef URAM_ARB_TIMEOUT_EN
      cnt_q <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q <= idx_d;
      done_q <= done_d;
      ptr_q <= ptr_d;
      uram_en_q <= uram_en_d;
      wr_en_q <= wr_en_d;
      addr_q <= addr_d;
      data_q <= data_d;
      emptied_q <= emptied_d;
      drain_req_q <= drain_req_d;
`ifdef URAM_ARB_TIMEOUT_EN
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end
  assign bus.o_core_grant = grant_q;
  assign bus.o_active_core = idx_q;
  assign bus.o_uram_en = uram_en_q;
  assign bus.o_uram_wr_en = wr_en_q;
  assign bus.o_uram_addr = addr_q;
  assign bus.o_uram_wr_data = data_q;
  assign bus.o_uram_emptied = emptied_q;
  assign bus.o_drain_req = drain_req_q;
`ifdef URAM_ARB_TIMEOUT_EN
  assign bus.o_timeout = timeout_q;
`endif
endmodule

// File: tb/tb_uram_row_arbiter.sv
// tb_uram_row_arbiter: directed self-checking bench for uram_row_arbiter
module tb_uram_row_arbiter;
  localparam int N = 4;
  localparam int AW = 12;
  localparam int DW = 32;
`ifdef URAM_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  uram_row_arbiter_if #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
  uram_row_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_in();
    bus.i_core_req = '0;
    bus.i_core_locked = '0;
    bus.i_core_uram_en = '0;
    bus.i_core_uram_wr_en = '0;
    bus.i_core_uram_addr = '0;
    bus.i_core_uram_wr_data = '0;
    bus.i_drain_done = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    clear_in();
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic drive(input int k, input logic en, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.i_core_uram_en[k] = en;
    bus.i_core_uram_wr_en[k] = we;
    bus.i_core_uram_addr[k*AW +: AW] = a;
    bus.i_core_uram_wr_data[k*DW +: DW] = d;
  endtask
  initial begin
    clear_in();
    do_reset();
    check("rst_grant", bus.o_core_grant, 0);
    check("rst_emptied", bus.o_uram_emptied, 1);
    check("rst_drain_req", bus.o_drain_req, 0);
    check("rst_active", bus.o_active_core, 0);
    check("rst_uram_en", bus.o_uram_en, 0);
    check("rst_wr_en", bus.o_uram_wr_en, 0);
    check("rst_addr", bus.o_uram_addr, 0);
    check("rst_data", bus.o_uram_wr_data, 0);
    bus.i_drain_done = 1'b1;
    tick();
    bus.i_drain_done = 1'b0;
    check("stray_done_drain_req", bus.o_drain_req, 0);
    bus.i_core_req = 4'b0100;
    tick();
    check("c2_grant", bus.o_core_grant, 4'b0100);
    check("c2_active", bus.o_active_core, 2);
    check("c2_emptied", bus.o_uram_emptied, 1);
    bus.i_core_req = 4'b0000;
    tick();
    check("abandon_grant", bus.o_core_grant, 0);
    bus.i_core_req = 4'b0100;
    tick();
    check("regrant_c2", bus.o_core_grant, 4'b0100);
    bus.i_core_locked[2] = 1'b1;
    drive(2, 1'b1, 1'b1, 12'h020, 32'hAB);
    tick();
    check("c2_uram_en", bus.o_uram_en, 1);
    check("c2_addr", bus.o_uram_addr, 12'h020);
    check("c2_data", bus.o_uram_wr_data, 32'hAB);
    check("c2_emptied_still", bus.o_uram_emptied, 1);
    drive(2, 1'b0, 1'b0, 12'h0, 32'h0);
    tick();
    check("c2_emptied_clr", bus.o_uram_emptied, 0);
    check("c2_grant_held", bus.o_core_grant, 4'b0100);
    check("c2_addr_hold", bus.o_uram_addr, 12'h0);
    bus.i_core_locked[2] = 1'b0;
    bus.i_core_req = 4'b0000;
    tick();
    check("c2_release", bus.o_core_grant, 0);
    do_reset();
    check("rst2_emptied", bus.o_uram_emptied, 1);
    bus.i_core_req = 4'b1111;
    for (int k = 0; k < N; k++) begin
      tick();
      check("rr_grant", bus.o_core_grant, 64'(1) << k);
      check("rr_active", bus.o_active_core, k);
      bus.i_core_locked[k] = 1'b1;
      if (k == 1) drive(1, 1'b1, 1'b1, 12'h010, 32'h5);
      tick();
      check("rr_held", bus.o_core_grant, 64'(1) << k);
      if (k == 1) begin
        check("c1_addr", bus.o_uram_addr, 12'h010);
        check("c1_data", bus.o_uram_wr_data, 32'h5);
        check("c1_wr_en", bus.o_uram_wr_en, 1);
      end
      drive(k, 1'b0, 1'b0, 12'h0, 32'h0);
      tick();
      check("rr_emptied", bus.o_uram_emptied, (k >= 1) ? 0 : 1);
      bus.i_core_locked[k] = 1'b0;
      tick();
      check("rr_release_gap", bus.o_core_grant, 0);
    end
    tick();
    check("drain_req_set", bus.o_drain_req, 1);
    check("drain_no_grant", bus.o_core_grant, 0);
    check("drain_uram_idle", bus.o_uram_en, 0);
    tick();
    check("drain_hold", bus.o_drain_req, 1);
    check("drain_hold_grant", bus.o_core_grant, 0);
    bus.i_drain_done = 1'b1;
    tick();
    bus.i_drain_done = 1'b0;
    check("drain_done_req", bus.o_drain_req, 0);
    check("drain_done_emptied", bus.o_uram_emptied, 1);
    check("drain_done_grant", bus.o_core_grant, 0);
    bus.i_core_req = 4'b0001;
    tick();
    check("rearm_grant", bus.o_core_grant, 4'b0001);
    check("rearm_active", bus.o_active_core, 0);
    bus.i_core_locked[0] = 1'b1;
    tick();
    drive(3, 1'b1, 1'b1, 12'h333, 32'hDEAD);
    drive(0, 1'b1, 1'b0, 12'h0AA, 32'h77);
    tick();
    check("ng_uram_en", bus.o_uram_en, 1);
    check("ng_wr_en", bus.o_uram_wr_en, 0);
    check("ng_addr", bus.o_uram_addr, 12'h0AA);
    check("ng_data", bus.o_uram_wr_data, 32'h77);
    drive(0, 1'b1, 1'b1, 12'h0AB, 32'h78);
    tick();
    drive(0, 1'b0, 1'b0, 12'h0, 32'h0);
    tick();
    check("c0_emptied_clr", bus.o_uram_emptied, 0);
    reset = 1'b1;
    tick();
    check("midrst_grant", bus.o_core_grant, 0);
    check("midrst_uram_en", bus.o_uram_en, 0);
    check("midrst_addr", bus.o_uram_addr, 0);
    check("midrst_emptied", bus.o_uram_emptied, 1);
    check("midrst_active", bus.o_active_core, 0);
    reset = 1'b0;
    clear_in();
`ifdef URAM_ARB_TIMEOUT_EN
    do_reset();
    bus.i_core_req = 4'b0110;
    tick();
    check("to_grant", bus.o_core_grant, 4'b0010);
    for (int i = 1; i < TO; i++) begin
      tick();
      check("to_wait", bus.o_core_grant, 4'b0010);
    end
    tick();
    check("to_revoke", bus.o_core_grant, 0);
    check("to_pulse", bus.o_timeout, 1);
    tick();
    check("to_next_grant", bus.o_core_grant, 4'b0100);
    check("to_pulse_end", bus.o_timeout, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uram_row_arbiter.md
Name: uram_row_arbiter

Overview:
- Responder side of the core row-sync interface: the arbiter plus barrier that answers each core's request/grant/locked handshake and drives its uram-emptied flag.
- Round-robin grants exclusive access to the shared row URAM, one core at a time.
- Forwards the granted core's URAM write port to the single physical URAM through a one-cycle register stage.
- Once every core has finished one locked session, hands the URAM to an external drain engine and re-arms all cores after the drain completes.

Parameters:
NUM_CORES, 4, number of cores in the row (2..16)
ADDR_W, 12, URAM address width
DATA_W, 32, URAM data width
TIMEOUT_CYCLES, 1024, max cycles a grant may wait for lock (only with URAM_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_core_req  in  NUM_CORES  per-core access request
o_core_grant  out  NUM_CORES  one-hot grant, at most one bit set
i_core_locked  in  NUM_CORES  per-core lock; falling edge = session done
i_core_uram_en  in  NUM_CORES  per-core URAM enable
i_core_uram_addr  in  NUM_CORES*ADDR_W  packed per-core addresses, core k at [k*ADDR_W +: ADDR_W]
i_core_uram_wr_data  in  NUM_CORES*DATA_W  packed per-core write data
i_core_uram_wr_en  in  NUM_CORES  per-core write enable
o_uram_en  out  1  physical URAM enable
o_uram_addr  out  ADDR_W  physical URAM address
o_uram_wr_data  out  DATA_W  physical URAM write data
o_uram_wr_en  out  1  physical URAM write enable
o_uram_emptied  out  1  broadcast to all cores: URAM drained
o_drain_req  out  1  request to external drain engine
i_drain_done  in  1  single-cycle pulse: drain complete
o_active_core  out  $clog2(NUM_CORES)  index of granted/last-granted core

Behaviour:
- Reset values:
  - o_core_grant=0, o_uram_en/o_uram_wr_en=0, o_uram_addr/o_uram_wr_data=0.
  - o_uram_emptied=1 (URAM empty at start), o_drain_req=0, o_active_core=0.
  - done mask=0; round-robin pointer=0; state=IDLE.
- Reset mid-operation aborts any session or drain immediately; the grant drops the cycle after reset is sampled.
- States: IDLE, WAIT_LOCK, LOCKED, DRAIN.
- IDLE:
  - Eligible cores are those with i_core_req=1 and done=0.
  - If any core is eligible, pick the first one at or after the pointer (wrapping NUM_CORES-1 to 0).
  - Register grant[idx]=1 and o_active_core=idx next cycle; go to WAIT_LOCK.
  - Arbitration latency is 1 cycle from req to grant.
  - If the done mask is full, go to DRAIN instead. DRAIN takes priority over new requests.
- WAIT_LOCK:
  - If i_core_locked[idx]=1, go to LOCKED.
  - If i_core_req[idx]=0 and locked=0, drop the grant, leave done[idx] unchanged, and return to IDLE. The pointer is not advanced.
- LOCKED:
  - Hold the grant.
  - When i_core_locked[idx]=0, drop the grant the next cycle, set done[idx]=1, set pointer=idx+1 (wrapping), and go to IDLE.
- URAM mux:
  - In WAIT_LOCK or LOCKED, the outputs register the granted core's en/addr/wr_data/wr_en: 1-cycle latency.
  - In all other states o_uram_en=o_uram_wr_en=0. Addr/data hold their last value.
  - Writes from non-granted cores are ignored.
- o_uram_emptied:
  - Cleared to 0 on the cycle after the first forwarded write (o_uram_en & o_uram_wr_en).
  - Set to 1 on the cycle after i_drain_done in DRAIN.
- DRAIN:
  - o_drain_req=1, no grants, URAM outputs idle.
  - On i_drain_done: o_drain_req=0, done mask cleared, pointer=0, go to IDLE.
  - i_drain_done outside DRAIN is ignored.
- Simultaneous events:
  - A lock fall and a new request in the same cycle are serialised: the release completes first, and re-arbitration happens in IDLE on the following cycle.
  - A core that is already done and re-requests before the drain waits until after the drain.

Optional Feature:
- Macro: URAM_ARB_TIMEOUT_EN.
- Defined:
  - Counter starts at WAIT_LOCK entry.
  - If locked is not seen within TIMEOUT_CYCLES cycles, revoke the grant, set done[idx]=1 (the core is skipped this round), advance the pointer, and return to IDLE.
  - A 1-cycle o_timeout pulse output is added.
- Undefined: no counter, no o_timeout port; WAIT_LOCK waits indefinitely.

Test Plan:
- Only core 2 requests after reset -> grant=4'b0100 one cycle later; o_active_core=2; o_uram_emptied=1 until its first write.
- Core 1 locked, writes addr=0x010 data=0x5 -> o_uram_addr=0x010, o_uram_wr_data=0x5, o_uram_wr_en=1 one cycle later; o_uram_emptied=0 the cycle after that.
- All 4 cores request simultaneously -> granted in order 0,1,2,3, each only after the previous locked falls. After core 3 releases, o_drain_req=1 and no grant is issued.
- In DRAIN, pulse i_drain_done -> o_drain_req=0 and o_uram_emptied=1 the next cycle; done mask cleared; core 0 re-requests and is granted.
- Core 3 (not granted) drives wr_en=1 while core 0 is locked -> o_uram_wr_en reflects only core 0. Assert reset mid-LOCKED -> grant=0 and all outputs at reset values next cycle.
- With URAM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, core 1 granted but never locks -> grant revoked after 8 cycles, o_timeout pulses, and the next eligible core is granted.
